// File: rtl/wb_regfile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_writeback_pkg
// Shared definitions for the write-back / register-file slice:
//   - default datapath and register-index widths
//   - write-data select encodings carried on WB_MemToReg
//   - the index of the hardwired-zero register
// No ports (package).
// -----------------------------------------------------------------------------
package wb_regfile_writeback_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Encoding 2'b11 is reserved and falls back to the ALU result.
    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11
    } mtr_e;

endpackage

// File: rtl/wb_data_select.sv
// -----------------------------------------------------------------------------
// wb_data_select
// Combinational write-back data mux with halfword sign-extension.
// Ports:
//   WB_MemToReg    in   2       write-data select
//   WB_halfbyte    in   1       halfword-load qualifier (only honoured for MEM)
//   WB_PCAddResult in   DATA_W  link value (PC+4)
//   WB_Read        in   DATA_W  memory load data
//   WB_ALUResult   in   DATA_W  ALU result
//   WB_WriteData   out  DATA_W  selected write-back data
// -----------------------------------------------------------------------------
module wb_data_select
    import wb_regfile_writeback_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        WB_MemToReg,
    input  logic              WB_halfbyte,
    input  logic [DATA_W-1:0] WB_PCAddResult,
    input  logic [DATA_W-1:0] WB_Read,
    input  logic [DATA_W-1:0] WB_ALUResult,
    output logic [DATA_W-1:0] WB_WriteData
);

    function automatic logic signed [DATA_W-1:0] sext_half(input logic [15:0] half);
        logic signed [DATA_W-1:0] ext;
        ext = {{(DATA_W-16){half[15]}}, half};
        return ext;
    endfunction

    always_comb begin
        WB_WriteData = WB_ALUResult;
        case (WB_MemToReg)
            MTR_MEM:  WB_WriteData = WB_halfbyte ? sext_half(WB_Read[15:0]) : WB_Read;
            MTR_LINK: WB_WriteData = WB_PCAddResult;
            default:  WB_WriteData = WB_ALUResult;
        endcase
    end

endmodule

// File: rtl/wb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// wb_regfile_writeback
// Write-back end of MEM/WB: selects the write-back data, commits it into a
// register file with a hardwired-zero entry, and serves two combinational
// ID-stage read ports with optional same-cycle write-through.
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   WB_RegWrite, WB_MemToReg,
//   WB_halfbyte, WB_jr              control from MEM/WB
//   WB_PCAddResult, WB_Read,
//   WB_ALUResult                    candidate write-back data
//   WB_RegDst                       destination index
//   ID_ReadReg1/2, ID_ReadData1/2   read ports
//   WB_WriteData                    selected write-back data
//   WB_WriteEn                      qualified write strobe
// -----------------------------------------------------------------------------
module wb_regfile_writeback
    import wb_regfile_writeback_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_REGS  = 2**ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic [1:0]        WB_MemToReg,
    input  logic              WB_halfbyte,
    input  logic              WB_jr,
    input  logic [DATA_W-1:0] WB_PCAddResult,
    input  logic [DATA_W-1:0] WB_Read,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [ADDR_W-1:0] WB_RegDst,
    input  logic [ADDR_W-1:0] ID_ReadReg1,
    input  logic [ADDR_W-1:0] ID_ReadReg2,
    output logic [DATA_W-1:0] ID_ReadData1,
    output logic [DATA_W-1:0] ID_ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic              WB_WriteEn
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wb_data_select #(
        .DATA_W(DATA_W)
    ) u_data_select (
        .WB_MemToReg   (WB_MemToReg),
        .WB_halfbyte   (WB_halfbyte),
        .WB_PCAddResult(WB_PCAddResult),
        .WB_Read       (WB_Read),
        .WB_ALUResult  (WB_ALUResult),
        .WB_WriteData  (WB_WriteData)
    );

    // Masking with ~Reset keeps bypass quiet and makes a write on an edge
    // coincident with Reset a no-op.
    assign WB_WriteEn = WB_RegWrite & ~WB_jr & (WB_RegDst != ZERO_IDX) & ~Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_WriteEn) begin
            regs[WB_RegDst] <= WB_WriteData;
        end
    end

    // Index 0 is forced to zero after the bypass so a bypassed read of r0
    // still returns zero.
    always_comb begin
        ID_ReadData1 = regs[ID_ReadReg1];
        if (BYPASS_EN && WB_WriteEn && (ID_ReadReg1 == WB_RegDst)) begin
            ID_ReadData1 = WB_WriteData;
        end
        if (ID_ReadReg1 == ZERO_IDX) begin
            ID_ReadData1 = '0;
        end
    end

    always_comb begin
        ID_ReadData2 = regs[ID_ReadReg2];
        if (BYPASS_EN && WB_WriteEn && (ID_ReadReg2 == WB_RegDst)) begin
            ID_ReadData2 = WB_WriteData;
        end
        if (ID_ReadReg2 == ZERO_IDX) begin
            ID_ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_writeback
// Bench for wb_regfile_writeback: one instance with write-through enabled and
// one without, sharing all inputs.
// -----------------------------------------------------------------------------
module tb_wb_regfile_writeback;
    import wb_regfile_writeback_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        WB_RegWrite;
    logic [1:0]  WB_MemToReg;
    logic        WB_halfbyte;
    logic        WB_jr;
    logic [31:0] WB_PCAddResult;
    logic [31:0] WB_Read;
    logic [31:0] WB_ALUResult;
    logic [4:0]  WB_RegDst;
    logic [4:0]  ID_ReadReg1;
    logic [4:0]  ID_ReadReg2;
    logic [31:0] ID_ReadData1, ID_ReadData2, WB_WriteData;
    logic        WB_WriteEn;
    logic [31:0] nb_ReadData1, nb_ReadData2, nb_WriteData;
    logic        nb_WriteEn;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb [$];
    logic [31:0] exp;

    wb_regfile_writeback #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_EN(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
        .WB_halfbyte(WB_halfbyte), .WB_jr(WB_jr), .WB_PCAddResult(WB_PCAddResult),
        .WB_Read(WB_Read), .WB_ALUResult(WB_ALUResult), .WB_RegDst(WB_RegDst),
        .ID_ReadReg1(ID_ReadReg1), .ID_ReadReg2(ID_ReadReg2),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .WB_WriteData(WB_WriteData), .WB_WriteEn(WB_WriteEn)
    );

    wb_regfile_writeback #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_EN(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
        .WB_halfbyte(WB_halfbyte), .WB_jr(WB_jr), .WB_PCAddResult(WB_PCAddResult),
        .WB_Read(WB_Read), .WB_ALUResult(WB_ALUResult), .WB_RegDst(WB_RegDst),
        .ID_ReadReg1(ID_ReadReg1), .ID_ReadReg2(ID_ReadReg2),
        .ID_ReadData1(nb_ReadData1), .ID_ReadData2(nb_ReadData2),
        .WB_WriteData(nb_WriteData), .WB_WriteEn(nb_WriteEn)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WB_RegWrite = 1'b0;
        WB_MemToReg = MTR_ALU;
        WB_halfbyte = 1'b0;
        WB_jr       = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] mtr, input logic hb, input logic jr,
                         input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pc);
        WB_RegWrite    = we;
        WB_MemToReg    = mtr;
        WB_halfbyte    = hb;
        WB_jr          = jr;
        WB_RegDst      = dst;
        WB_ALUResult   = alu;
        WB_Read        = rd;
        WB_PCAddResult = pc;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle();
        ID_ReadReg1 = 5'd5;
        ID_ReadReg2 = 5'd31;
        #1 Reset = 1'b1;
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd5, 32'h55, 32'h0, 32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL rst_rd1 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (32'(WB_WriteEn) !== exp) begin errors++; $display("FAIL rst_we got %h want %h", WB_WriteEn, exp); end
        // write held across an edge while Reset is high must be discarded
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        idle();
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL rst_coincident got %h want %h", ID_ReadData1, exp); end

        for (int i = 1; i < 32; i++) begin
            step();
            drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'(i), (i == 5) ? 32'h1234 : 32'hA500_0000 + 32'(i), 32'h0, 32'h0);
        end
        step();
        idle();
        sb.push_back(32'h1234);
        sb.push_back(32'hA500_001F);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL fill_r5 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData2 !== exp) begin errors++; $display("FAIL fill_r31 got %h want %h", ID_ReadData2, exp); end

        // mid-cycle reset: clearing must be visible with no clock edge
        Reset = 1'b1;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL async_r5 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (nb_ReadData2 !== exp) begin errors++; $display("FAIL async_nb_r31 got %h want %h", nb_ReadData2, exp); end
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ID_ReadReg1 = 5'(i);
            ID_ReadReg2 = 5'(31 - i);
            sb.push_back(32'h0);
            sb.push_back(32'h0);
            #1;
            checks++; exp = sb.pop_front();
            if (ID_ReadData1 !== exp) begin errors++; $display("FAIL clear_rd1[%0d] got %h want %h", i, ID_ReadData1, exp); end
            checks++; exp = sb.pop_front();
            if (nb_ReadData2 !== exp) begin errors++; $display("FAIL clear_nb_rd2[%0d] got %h want %h", 31 - i, nb_ReadData2, exp); end
        end
    endtask

    task automatic test_alu_write();
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
        sb.push_back(32'hDEAD_BEEF);
        sb.push_back(32'h1);
        #1;
        checks++; exp = sb.pop_front();
        if (WB_WriteData !== exp) begin errors++; $display("FAIL alu_wd got %h want %h", WB_WriteData, exp); end
        checks++; exp = sb.pop_front();
        if (32'(WB_WriteEn) !== exp) begin errors++; $display("FAIL alu_we got %h want %h", WB_WriteEn, exp); end
        step();
        idle();
        ID_ReadReg1 = 5'd9;
        sb.push_back(32'hDEAD_BEEF);
        #1;
        checks++; exp = sb.pop_front();
        if (nb_ReadData1 !== exp) begin errors++; $display("FAIL alu_r9 got %h want %h", nb_ReadData1, exp); end
    endtask

    task automatic test_halfword();
        logic [1:0]  mtr [5] = '{MTR_MEM, MTR_MEM, MTR_MEM, MTR_ALU, MTR_RSVD};
        logic        hb  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] rd  [5] = '{32'h0000_8001, 32'h0000_8001, 32'hABCD_7FFF, 32'hFFFF_8001, 32'hFFFF_8001};
        logic [31:0] want[5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF, 32'h1234_5678, 32'h1234_5678};
        for (int k = 0; k < 5; k++) begin
            step();
            drive(1'b1, mtr[k], hb[k], 1'b0, 5'd3, 32'h1234_5678, rd[k], 32'h0000_0080);
            sb.push_back(want[k]);
            #1;
            checks++; exp = sb.pop_front();
            if (WB_WriteData !== exp) begin errors++; $display("FAIL sel_wd[%0d] got %h want %h", k, WB_WriteData, exp); end
            sb.push_back(want[k]);
            step();
            idle();
            ID_ReadReg2 = 5'd3;
            #1;
            checks++; exp = sb.pop_front();
            if (nb_ReadData2 !== exp) begin errors++; $display("FAIL sel_r3[%0d] got %h want %h", k, nb_ReadData2, exp); end
        end
    endtask

    task automatic test_link_bypass();
        step();
        drive(1'b1, MTR_LINK, 1'b1, 1'b0, 5'd31, 32'h0000_0999, 32'h0000_0888, 32'h0000_0040);
        ID_ReadReg1 = 5'd31;
        ID_ReadReg2 = 5'd31;
        sb.push_back(32'h40);
        sb.push_back(32'h40);
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL byp_rd1 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData2 !== exp) begin errors++; $display("FAIL byp_rd2 got %h want %h", ID_ReadData2, exp); end
        checks++; exp = sb.pop_front();
        if (nb_ReadData1 !== exp) begin errors++; $display("FAIL byp_nb_old got %h want %h", nb_ReadData1, exp); end
        step();
        idle();
        sb.push_back(32'h40);
        sb.push_back(32'h40);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL link_r31_p1 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (nb_ReadData2 !== exp) begin errors++; $display("FAIL link_r31_p2 got %h want %h", nb_ReadData2, exp); end
    endtask

    task automatic test_zero_jr();
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        ID_ReadReg1 = 5'd0;
        ID_ReadReg2 = 5'd0;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (32'(WB_WriteEn) !== exp) begin errors++; $display("FAIL r0_we got %h want %h", WB_WriteEn, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL r0_byp_rd1 got %h want %h", ID_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData2 !== exp) begin errors++; $display("FAIL r0_byp_rd2 got %h want %h", ID_ReadData2, exp); end
        step();
        idle();
        sb.push_back(32'h0);
        #1;
        checks++; exp = sb.pop_front();
        if (nb_ReadData1 !== exp) begin errors++; $display("FAIL r0_after got %h want %h", nb_ReadData1, exp); end

        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd7, 32'h0000_0077, 32'h0, 32'h0);
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b1, 5'd7, 32'h0000_0099, 32'h0, 32'h0);
        ID_ReadReg1 = 5'd7;
        sb.push_back(32'h0);
        sb.push_back(32'h77);
        #1;
        checks++; exp = sb.pop_front();
        if (32'(WB_WriteEn) !== exp) begin errors++; $display("FAIL jr_we got %h want %h", WB_WriteEn, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL jr_nobyp got %h want %h", ID_ReadData1, exp); end
        step();
        idle();
        sb.push_back(32'h77);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL jr_r7 got %h want %h", ID_ReadData1, exp); end
    endtask

    task automatic test_no_bypass();
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd12, 32'h0000_0011, 32'h0, 32'h0);
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd12, 32'h0000_0022, 32'h0, 32'h0);
        ID_ReadReg1 = 5'd12;
        sb.push_back(32'h11);
        sb.push_back(32'h22);
        #1;
        checks++; exp = sb.pop_front();
        if (nb_ReadData1 !== exp) begin errors++; $display("FAIL nobyp_same got %h want %h", nb_ReadData1, exp); end
        checks++; exp = sb.pop_front();
        if (ID_ReadData1 !== exp) begin errors++; $display("FAIL byp_same got %h want %h", ID_ReadData1, exp); end
        step();
        idle();
        sb.push_back(32'h22);
        #1;
        checks++; exp = sb.pop_front();
        if (nb_ReadData1 !== exp) begin errors++; $display("FAIL nobyp_next got %h want %h", nb_ReadData1, exp); end
    endtask

    task automatic test_back_to_back();
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd9, 32'hAAAA_0001, 32'h0, 32'h0);
        step();
        drive(1'b1, MTR_ALU, 1'b0, 1'b0, 5'd9, 32'hBBBB_0002, 32'h0, 32'h0);
        ID_ReadReg2 = 5'd9;
        sb.push_back(32'hBBBB_0002);
        sb.push_back(32'hAAAA_0001);
        #1;
        checks++; exp = sb.pop_front();
        if (ID_ReadData2 !== exp) begin errors++; $display("FAIL b2b_byp got %h want %h", ID_ReadData2, exp); end
        checks++; exp = sb.pop_front();
        if (nb_ReadData2 !== exp) begin errors++; $display("FAIL b2b_nb_old got %h want %h", nb_ReadData2, exp); end
        step();
        idle();
        sb.push_back(32'hBBBB_0002);
        #1;
        checks++; exp = sb.pop_front();
        if (nb_ReadData2 !== exp) begin errors++; $display("FAIL b2b_last got %h want %h", nb_ReadData2, exp); end
    endtask

    initial begin
        WB_RegDst      = 5'd0;
        WB_ALUResult   = 32'h0;
        WB_Read        = 32'h0;
        WB_PCAddResult = 32'h0;
        test_reset();
        test_alu_write();
        test_halfword();
        test_link_bypass();
        test_zero_jr();
        test_no_bypass();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
